// File: rtl/sys_defs.sv
// sys_defs: shared widths, message/command encodings and bus FSM states
package sys_defs;
  localparam int DCACHE_WORD_IN_BITS = 64;
  localparam int DCACHE_IDX_W = 5;
  localparam int DCACHE_TAG_W = DCACHE_WORD_IN_BITS - DCACHE_IDX_W - 3;
  typedef enum logic [1:0] {NONE, GET_S, GET_M, PUT_M} message_t;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEM_ST, MEM_LD, MEM_WAIT, RSP} bus_state_t;
endpackage

// File: rtl/dcache_bus_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a tie goes to the core not granted last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id
);
  assign gnt_id = &req ? ~last_grant : req[1];
endmodule

// File: rtl/dcache_bus_ctrl.sv
// dcache_bus_ctrl: snooping bus controller between two Dcaches and tagged main memory
module dcache_bus_ctrl
  import sys_defs::*;
#(
  parameter int SNOOP_WIN = 2,
  parameter int MEM_TAG_W = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           dc2bus_req_en_i,
  input  logic [1:0][DCACHE_TAG_W-1:0]         dc2bus_req_tag_i,
  input  logic [1:0][DCACHE_IDX_W-1:0]         dc2bus_req_idx_i,
  input  logic [1:0][DCACHE_WORD_IN_BITS-1:0]  dc2bus_req_data_i,
  input  message_t [1:0]                       dc2bus_req_message_i,
  input  logic [1:0]                           dc2bus_rsp_vld_i,
  input  logic [1:0][DCACHE_WORD_IN_BITS-1:0]  dc2bus_rsp_data_i,
  input  logic [1:0]                           dc2bus_rsp_ack_i,
  output logic                                 bus2dc_req_ack_o,
  output logic                                 bus2dc_req_id_o,
  output logic [DCACHE_TAG_W-1:0]              bus2dc_req_tag_o,
  output logic [DCACHE_IDX_W-1:0]              bus2dc_req_idx_o,
  output message_t                             bus2dc_req_message_o,
  output logic                                 bus2dc_rsp_vld_o,
  output logic                                 bus2dc_rsp_id_o,
  output logic [DCACHE_WORD_IN_BITS-1:0]       bus2dc_rsp_data_o,
  output logic [1:0]                           bus2mem_command_o,
  output logic [63:0]                          bus2mem_addr_o,
  output logic [63:0]                          bus2mem_data_o,
  input  logic [MEM_TAG_W-1:0]                 mem2bus_response_i,
  input  logic [63:0]                          mem2bus_data_i,
  input  logic [MEM_TAG_W-1:0]                 mem2bus_tag_i
);
  localparam int CNT_W = $clog2(SNOOP_WIN + 1);
  bus_state_t state_q, state_d;
  logic win_q, gnt, supply, snoop_last, mem_ok, tag_hit, bcast, rsp, ld, st;
  logic [DCACHE_TAG_W-1:0] tag_q;
  logic [DCACHE_IDX_W-1:0] idx_q;
  message_t msg_q;
  logic [63:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MEM_TAG_W-1:0] mtag_q;
  rr_arb2 u_arb (.req(dc2bus_req_en_i), .last_grant(win_q), .gnt_id(gnt));
  assign supply = dc2bus_rsp_vld_i[~win_q];
  assign snoop_last = cnt_q == CNT_W'(SNOOP_WIN - 1);
  assign mem_ok = |mem2bus_response_i;
  assign tag_hit = |mtag_q && mem2bus_tag_i == mtag_q;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: one transaction at a time from grant through fill or store
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = |dc2bus_req_en_i ? BCAST : IDLE;
      BCAST:    state_d = msg_q == PUT_M ? MEM_ST : SNOOP;
      SNOOP:    state_d = supply ? (msg_q == GET_M ? RSP : WB) : snoop_last ? MEM_LD : SNOOP;
      WB:       state_d = mem_ok ? RSP : WB;
      MEM_ST:   state_d = mem_ok ? IDLE : MEM_ST;
      MEM_LD:   state_d = mem_ok ? MEM_WAIT : MEM_LD;
      MEM_WAIT: state_d = tag_hit ? RSP : MEM_WAIT;
      RSP:      state_d = dc2bus_rsp_ack_i[win_q] ? IDLE : RSP;
      default:  state_d = IDLE;
    endcase
  end
  // datapath: win_q is both the current requester and the round-robin history,
  // and data_q carries PUT_M data, snooped data or memory data in turn
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      win_q <= 1'b1;
      tag_q <= '0;
      idx_q <= '0;
      msg_q <= NONE;
      data_q <= '0;
      cnt_q <= '0;
      mtag_q <= '0;
    end else begin
      if (state_q == IDLE && |dc2bus_req_en_i) begin
        win_q <= gnt;
        tag_q <= dc2bus_req_tag_i[gnt];
        idx_q <= dc2bus_req_idx_i[gnt];
        msg_q <= message_t'(dc2bus_req_message_i[gnt]);
        data_q <= dc2bus_req_data_i[gnt];
      end
      cnt_q <= state_q == SNOOP ? cnt_q + 1'b1 : '0;
      if (state_q == SNOOP && supply) data_q <= dc2bus_rsp_data_i[~win_q];
      if (state_q == MEM_LD && mem_ok) mtag_q <= mem2bus_response_i;
      if (state_q == MEM_WAIT && tag_hit) begin
        data_q <= mem2bus_data_i;
        mtag_q <= '0;
      end
    end
  assign bcast = state_q == BCAST;
  assign rsp = state_q == RSP;
  assign ld = state_q == MEM_LD;
  assign st = state_q == WB || state_q == MEM_ST;
  // outputs decode straight from the state so reset clears them at once
  always_comb begin
    bus2dc_req_ack_o = bcast;
    bus2dc_req_id_o = bcast & win_q;
    bus2dc_req_tag_o = bcast ? tag_q : '0;
    bus2dc_req_idx_o = bcast ? idx_q : '0;
    bus2dc_req_message_o = bcast ? msg_q : NONE;
    bus2dc_rsp_vld_o = rsp;
    bus2dc_rsp_id_o = rsp & win_q;
    bus2dc_rsp_data_o = rsp ? data_q : '0;
    bus2mem_command_o = ld ? BUS_LOAD : st ? BUS_STORE : BUS_NONE;
    bus2mem_addr_o = ld | st ? {tag_q, idx_q, 3'b000} : '0;
    bus2mem_data_o = st ? data_q : '0;
  end
endmodule

// File: tb/tb_dcache_bus_ctrl.sv
// tb_dcache_bus_ctrl: directed and randomized transactions against a transaction-level model
module tb_dcache_bus_ctrl;
  import sys_defs::*;
  localparam int MEM_TAG_W = 4;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_en, rsp_vld, rsp_ack;
  logic [1:0][DCACHE_TAG_W-1:0] req_tag;
  logic [1:0][DCACHE_IDX_W-1:0] req_idx;
  logic [1:0][63:0] req_data, rsp_data;
  message_t [1:0] req_msg;
  logic [MEM_TAG_W-1:0] mem_resp, mem_tag;
  logic [63:0] mem_data;
  logic ack_o, id_o, vld_o, rid_o;
  logic [DCACHE_TAG_W-1:0] tag_o;
  logic [DCACHE_IDX_W-1:0] idx_o;
  message_t msg_o;
  logic [63:0] rdata_o, addr_o, wdata_o;
  logic [1:0] cmd_o;
  int errors = 0, checks = 0, last_win = 1, w;
  dcache_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .dc2bus_req_en_i(req_en), .dc2bus_req_tag_i(req_tag), .dc2bus_req_idx_i(req_idx),
    .dc2bus_req_data_i(req_data), .dc2bus_req_message_i(req_msg),
    .dc2bus_rsp_vld_i(rsp_vld), .dc2bus_rsp_data_i(rsp_data), .dc2bus_rsp_ack_i(rsp_ack),
    .bus2dc_req_ack_o(ack_o), .bus2dc_req_id_o(id_o), .bus2dc_req_tag_o(tag_o),
    .bus2dc_req_idx_o(idx_o), .bus2dc_req_message_o(msg_o),
    .bus2dc_rsp_vld_o(vld_o), .bus2dc_rsp_id_o(rid_o), .bus2dc_rsp_data_o(rdata_o),
    .bus2mem_command_o(cmd_o), .bus2mem_addr_o(addr_o), .bus2mem_data_o(wdata_o),
    .mem2bus_response_i(mem_resp), .mem2bus_data_i(mem_data), .mem2bus_tag_i(mem_tag)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int c, input message_t m, input logic [DCACHE_TAG_W-1:0] t,
                         input logic [DCACHE_IDX_W-1:0] x, input logic [63:0] d);
    req_msg[c] = m;
    req_tag[c] = t;
    req_idx[c] = x;
    req_data[c] = d;
    req_en[c] = 1'b1;
  endtask
  task automatic rand_req(input int c);
    set_req(c, message_t'(2'($urandom_range(1, 3))), DCACHE_TAG_W'({$urandom, $urandom}),
            DCACHE_IDX_W'($urandom), {$urandom, $urandom});
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack_o), 64'd0);
    check({tag, "_vld"}, 64'(vld_o), 64'd0);
    check({tag, "_cmd"}, 64'(cmd_o), 64'(BUS_NONE));
    check({tag, "_addr"}, addr_o, 64'd0);
    check({tag, "_rdata"}, rdata_o, 64'd0);
    check({tag, "_msg"}, 64'(msg_o), 64'(NONE));
  endtask
  // s: snoop cycle of peer supply (2 = none); d: cycles memory holds response 0;
  // wt: cycles before the load tag returns; a: cycles before the requester acks
  task automatic run_txn(input int s, input int d, input int wt, input int a, input logic [63:0] sd,
                         input logic [MEM_TAG_W-1:0] mtag, input logic [63:0] mdata, output int win);
    int n;
    logic hit;
    logic [1:0] ec;
    logic [63:0] ea, ed, ef;
    message_t emsg;
    win = (req_en == 2'b11) ? 1 - last_win : int'(req_en[1]);
    emsg = message_t'(req_msg[win]);
    ea = {req_tag[win], req_idx[win], 3'b000};
    hit = emsg != PUT_M && s < 2;
    ec = (emsg == PUT_M || (hit && emsg == GET_S)) ? BUS_STORE : hit ? BUS_NONE : BUS_LOAD;
    ed = emsg == PUT_M ? req_data[win] : sd;
    ef = hit ? sd : mdata;
    n = 0;
    while (!ack_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_lat", 64'(n), 64'd1);
    check("req_id", 64'(id_o), 64'(win));
    check("req_tag", 64'(tag_o), 64'(req_tag[win]));
    check("req_idx", 64'(idx_o), 64'(req_idx[win]));
    check("req_msg", 64'(msg_o), 64'(emsg));
    last_win = win;
    req_en[win] = 1'b0;
    rsp_vld = 2'b11;
    rsp_data = {$urandom, $urandom, $urandom, $urandom};
    rsp_ack = 2'($urandom);
    if (emsg != PUT_M)
      for (int i = 0; i < ((s == 0) ? 1 : 2); i++) begin
        @(negedge clk);
        check("snoop_cmd", 64'(cmd_o), 64'(BUS_NONE));
        check("snoop_vld", 64'(vld_o), 64'd0);
        rsp_vld[1-win] = s == i;
        rsp_data[1-win] = (s == i) ? sd : {$urandom, $urandom};
        rsp_data[win] = {$urandom, $urandom};
      end
    @(negedge clk);
    rsp_vld = 2'b00;
    rsp_ack = 2'b00;
    if (ec != BUS_NONE) begin
      for (int i = 0; i <= d; i++) begin
        if (i > 0) @(negedge clk);
        check("mem_cmd", 64'(cmd_o), 64'(ec));
        check("mem_addr", addr_o, ea);
        if (ec == BUS_STORE) check("mem_data", wdata_o, ed);
        mem_resp = (i < d) ? '0 : (ec == BUS_LOAD) ? mtag : MEM_TAG_W'($urandom_range(1, 15));
        if (ec == BUS_LOAD) begin
          mem_tag = mtag;
          mem_data = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      mem_resp = '0;
      if (ec == BUS_LOAD) begin
        for (int i = 0; i < wt; i++) begin
          if (i > 0) @(negedge clk);
          check("wait_cmd", 64'(cmd_o), 64'(BUS_NONE));
          check("wait_vld", 64'(vld_o), 64'd0);
          mem_tag = (i % 2 == 1) ? '0 : mtag ^ MEM_TAG_W'($urandom_range(1, 15));
          mem_data = {$urandom, $urandom};
        end
        if (wt > 0) @(negedge clk);
        mem_tag = mtag;
        mem_data = mdata;
        @(negedge clk);
        mem_tag = '0;
      end
    end
    if (emsg != PUT_M) begin
      for (int i = 0; i <= a; i++) begin
        if (i > 0) @(negedge clk);
        check("rsp_vld", 64'(vld_o), 64'd1);
        check("rsp_id", 64'(rid_o), 64'(win));
        check("rsp_data", rdata_o, ef);
        check("rsp_cmd", 64'(cmd_o), 64'(BUS_NONE));
        rsp_ack = (i == a) ? 2'(1 << win) : 2'(1 << (1 - win));
      end
      @(negedge clk);
      rsp_ack = 2'b00;
    end
    check("end_vld", 64'(vld_o), 64'd0);
    check("end_cmd", 64'(cmd_o), 64'(BUS_NONE));
  endtask
  initial begin
    rst = 1'b0;
    req_en = '0; req_tag = '0; req_idx = '0; req_data = '0; req_msg = '0;
    rsp_vld = '0; rsp_data = '0; rsp_ack = '0;
    mem_resp = '0; mem_tag = '0; mem_data = '0;
    #1;
    check_idle_outputs("reset");
    check("reset_id", 64'(id_o), 64'd0);
    check("reset_wdata", wdata_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, GET_S, DCACHE_TAG_W'(56'h12), 5'd3, 64'h0);
    run_txn(2, 0, 3, 1, 64'h0, 4'd3, 64'hDEAD, w);
    check("t1_win", 64'(w), 64'd0);
    set_req(1, GET_M, DCACHE_TAG_W'(56'h345), 5'd9, 64'h0);
    run_txn(1, 0, 0, 0, 64'h1234, 4'd1, 64'hBAD, w);
    check("t3_win", 64'(w), 64'd1);
    set_req(1, GET_S, DCACHE_TAG_W'(56'h678), 5'd31, 64'h0);
    run_txn(0, 1, 0, 0, 64'h55, 4'd1, 64'hBAD, w);
    check("t4_win", 64'(w), 64'd1);
    set_req(0, PUT_M, DCACHE_TAG_W'(56'h9A), 5'd0, 64'h77);
    run_txn(0, 3, 0, 0, 64'h0, 4'd1, 64'h0, w);
    check("t5_win", 64'(w), 64'd0);
    set_req(0, GET_S, DCACHE_TAG_W'(56'hABC), 5'd7, 64'h0);
    @(negedge clk);
    check("t6_ack", 64'(ack_o), 64'd1);
    req_en = 2'b00;
    repeat (3) @(negedge clk);
    check("t6_load", 64'(cmd_o), 64'(BUS_LOAD));
    mem_resp = 4'd5;
    @(negedge clk);
    mem_resp = '0;
    #2 rst = 1'b0;
    #1 check_idle_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    last_win = 1;
    mem_tag = 4'd5;
    mem_data = 64'hBEEF;
    repeat (3) begin
      @(negedge clk);
      check("t6_stale_vld", 64'(vld_o), 64'd0);
      check("t6_stale_ack", 64'(ack_o), 64'd0);
    end
    mem_tag = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_req(0, GET_M, DCACHE_TAG_W'(56'h1), 5'd1, 64'h0);
    set_req(1, GET_S, DCACHE_TAG_W'(56'h2), 5'd2, 64'h0);
    run_txn(2, 0, 1, 0, 64'h0, 4'd7, 64'h1111, w);
    check("t2_first", 64'(w), 64'd0);
    set_req(0, GET_S, DCACHE_TAG_W'(56'h3), 5'd3, 64'h0);
    run_txn(2, 1, 0, 0, 64'h0, 4'd15, 64'h2222, w);
    check("t2_second", 64'(w), 64'd1);
    run_txn(1, 0, 0, 1, 64'h3333, 4'd2, 64'h0, w);
    check("t2_third", 64'(w), 64'd0);
    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < 2; c++)
        if (!req_en[c] && $urandom_range(0, 1) == 1) rand_req(c);
      if (req_en == 2'b00) rand_req(int'($urandom_range(0, 1)));
      run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), {$urandom, $urandom}, MEM_TAG_W'($urandom_range(1, 15)),
              {$urandom, $urandom}, w);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
